// File: rtl/ex_mem_stage_reg.sv
// Ex/Mem pipeline register: captures Exec results, resolves branch/jump redirect, forms the forwarding value.
// Optional macro OVERFLOW_TRAP_EN: turns an ALU overflow on a register write into a suppressed write plus OvfExc_Mem.
module ex_mem_stage_reg #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [WIDTH-1:0] ALU_ans_Ex,
  input  logic [WIDTH-1:0] busB_out_Ex,
  input  logic [WIDTH-1:0] B_Addr_Ex,
  input  logic [WIDTH-1:0] J_Addr_out_Ex,
  input  logic [WIDTH-1:0] PC_Addr_Ex,
  input  logic [4:0]       Reg_Target_Ex,
  input  logic             ZF_Ex,
  input  logic             OF_Ex,
  input  logic             Sign_Ex,
  input  logic             Branch_Ex,
  input  logic             Jump_Ex,
  input  logic             Jal_Ex,
  input  logic             MemToReg_Ex,
  input  logic             RegWr_Ex,
  input  logic             MemWr_Ex,
  input  logic             WrByte_Ex,
  input  logic [1:0]       LoadByte_Ex,
  output logic [WIDTH-1:0] ALU_ans_Mem,
  output logic [WIDTH-1:0] busB_Mem,
  output logic [WIDTH-1:0] WrData_Mem,
  output logic [4:0]       Reg_Target_Mem,
  output logic             MemToReg_Mem,
  output logic             RegWr_Mem,
  output logic             MemWr_Mem,
  output logic             WrByte_Mem,
  output logic [1:0]       LoadByte_Mem,
  output logic             Redirect_Mem,
  output logic [WIDTH-1:0] Redirect_Addr_Mem,
  output logic [WIDTH-1:0] Ex_Mem_ByPassing,
  output logic             Valid_Mem,
  output logic             OvfExc_Mem
);

  logic             w_load;
  logic             w_live;
  logic             w_taken;
  logic             w_ovf;
  logic             w_regwr;
  logic [WIDTH-1:0] w_wrdata;
  logic [WIDTH-1:0] w_redir_addr;
  logic [4:0]       w_target;
  logic             w_unused;

  logic             r_valid;
  logic [WIDTH-1:0] r_alu;
  logic [WIDTH-1:0] r_busb;
  logic [WIDTH-1:0] r_wrdata;
  logic [4:0]       r_target;
  logic             r_memtoreg;
  logic             r_regwr;
  logic             r_memwr;
  logic             r_wrbyte;
  logic [1:0]       r_loadbyte;
  logic             r_redirect;
  logic [WIDTH-1:0] r_redir_addr;
  logic             r_ovf;

  // Flush overrides Stall so a bubble is always inserted; control bits are gated at load time.
  assign w_load       = ~Stall | Flush;
  assign w_live       = ~Flush;
  assign w_taken      = (Branch_Ex & ZF_Ex) | Jump_Ex | Jal_Ex;
  assign w_redir_addr = (Jump_Ex | Jal_Ex) ? J_Addr_out_Ex : B_Addr_Ex;
  assign w_wrdata     = Jal_Ex ? PC_Addr_Ex : ALU_ans_Ex;
  assign w_target     = Jal_Ex ? LINK_REG : Reg_Target_Ex;

`ifdef OVERFLOW_TRAP_EN
  assign w_ovf    = OF_Ex & RegWr_Ex & ~Jal_Ex;
  assign w_unused = Sign_Ex;
`else
  assign w_ovf    = 1'b0;
  assign w_unused = OF_Ex ^ Sign_Ex;
`endif

  assign w_regwr = Jal_Ex | (RegWr_Ex & ~w_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_alu        <= '0;
      r_busb       <= '0;
      r_wrdata     <= '0;
      r_target     <= '0;
      r_memtoreg   <= 1'b0;
      r_regwr      <= 1'b0;
      r_memwr      <= 1'b0;
      r_wrbyte     <= 1'b0;
      r_loadbyte   <= '0;
      r_redirect   <= 1'b0;
      r_redir_addr <= '0;
      r_ovf        <= 1'b0;
    end else if (w_load) begin
      r_valid      <= w_live;
      r_alu        <= ALU_ans_Ex;
      r_busb       <= busB_out_Ex;
      r_wrdata     <= w_wrdata;
      r_target     <= w_target;
      r_memtoreg   <= MemToReg_Ex & w_live;
      r_regwr      <= w_regwr & w_live;
      r_memwr      <= MemWr_Ex & w_live;
      r_wrbyte     <= WrByte_Ex & w_live;
      r_loadbyte   <= LoadByte_Ex;
      r_redirect   <= w_taken & w_live;
      r_redir_addr <= w_redir_addr;
      r_ovf        <= w_ovf & w_live;
    end
  end

  assign ALU_ans_Mem       = r_alu;
  assign busB_Mem          = r_busb;
  assign WrData_Mem        = r_wrdata;
  assign Ex_Mem_ByPassing  = r_wrdata;
  assign Reg_Target_Mem    = r_target;
  assign MemToReg_Mem      = r_memtoreg;
  assign RegWr_Mem         = r_regwr;
  assign MemWr_Mem         = r_memwr;
  assign WrByte_Mem        = r_wrbyte;
  assign LoadByte_Mem      = r_loadbyte;
  assign Redirect_Mem      = r_redirect;
  assign Redirect_Addr_Mem = r_redir_addr;
  assign Valid_Mem         = r_valid;
  assign OvfExc_Mem        = r_ovf;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed cases plus randomized traffic against a behavioural model.
module tb_ex_mem_stage_reg;
  localparam int unsigned W = 32;
`ifdef OVERFLOW_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic Stall, Flush;
  logic [W-1:0] ALU_ans_Ex, busB_out_Ex, B_Addr_Ex, J_Addr_out_Ex, PC_Addr_Ex;
  logic [4:0] Reg_Target_Ex;
  logic ZF_Ex, OF_Ex, Sign_Ex, Branch_Ex, Jump_Ex, Jal_Ex;
  logic MemToReg_Ex, RegWr_Ex, MemWr_Ex, WrByte_Ex;
  logic [1:0] LoadByte_Ex;
  logic [W-1:0] ALU_ans_Mem, busB_Mem, WrData_Mem, Redirect_Addr_Mem, Ex_Mem_ByPassing;
  logic [4:0] Reg_Target_Mem;
  logic MemToReg_Mem, RegWr_Mem, MemWr_Mem, WrByte_Mem, Redirect_Mem, Valid_Mem, OvfExc_Mem;
  logic [1:0] LoadByte_Mem;

  ex_mem_stage_reg #(.WIDTH(W), .LINK_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .ALU_ans_Ex(ALU_ans_Ex), .busB_out_Ex(busB_out_Ex), .B_Addr_Ex(B_Addr_Ex),
    .J_Addr_out_Ex(J_Addr_out_Ex), .PC_Addr_Ex(PC_Addr_Ex), .Reg_Target_Ex(Reg_Target_Ex),
    .ZF_Ex(ZF_Ex), .OF_Ex(OF_Ex), .Sign_Ex(Sign_Ex), .Branch_Ex(Branch_Ex),
    .Jump_Ex(Jump_Ex), .Jal_Ex(Jal_Ex), .MemToReg_Ex(MemToReg_Ex), .RegWr_Ex(RegWr_Ex),
    .MemWr_Ex(MemWr_Ex), .WrByte_Ex(WrByte_Ex), .LoadByte_Ex(LoadByte_Ex),
    .ALU_ans_Mem(ALU_ans_Mem), .busB_Mem(busB_Mem), .WrData_Mem(WrData_Mem),
    .Reg_Target_Mem(Reg_Target_Mem), .MemToReg_Mem(MemToReg_Mem), .RegWr_Mem(RegWr_Mem),
    .MemWr_Mem(MemWr_Mem), .WrByte_Mem(WrByte_Mem), .LoadByte_Mem(LoadByte_Mem),
    .Redirect_Mem(Redirect_Mem), .Redirect_Addr_Mem(Redirect_Addr_Mem),
    .Ex_Mem_ByPassing(Ex_Mem_ByPassing), .Valid_Mem(Valid_Mem), .OvfExc_Mem(OvfExc_Mem)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: what the instruction sitting in the Mem slot must present.
  logic m_valid, m_regwr, m_memwr, m_wrbyte, m_m2r, m_redir, m_ovf;
  logic [1:0] m_lb;
  logic [4:0] m_tgt;
  logic [W-1:0] m_alu, m_busb, m_wrdata, m_raddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_valid, m_regwr, m_memwr, m_wrbyte, m_m2r, m_redir, m_ovf} = '0;
      m_lb = '0; m_tgt = '0; m_alu = '0; m_busb = '0; m_wrdata = '0; m_raddr = '0;
    end else if (Flush || !Stall) begin
      bit real_insn, ovf, taken;
      real_insn = !Flush;
      ovf   = OVF_EN && OF_Ex && RegWr_Ex && !Jal_Ex;
      taken = (Branch_Ex && ZF_Ex) || Jump_Ex || Jal_Ex;
      m_valid  = real_insn;
      m_alu    = ALU_ans_Ex;
      m_busb   = busB_out_Ex;
      m_lb     = LoadByte_Ex;
      m_wrdata = Jal_Ex ? PC_Addr_Ex : ALU_ans_Ex;
      m_tgt    = Jal_Ex ? 5'd31 : Reg_Target_Ex;
      m_raddr  = (Jump_Ex || Jal_Ex) ? J_Addr_out_Ex : B_Addr_Ex;
      m_regwr  = real_insn && (Jal_Ex || (RegWr_Ex && !ovf));
      m_memwr  = real_insn && MemWr_Ex;
      m_wrbyte = real_insn && WrByte_Ex;
      m_m2r    = real_insn && MemToReg_Ex;
      m_redir  = real_insn && taken;
      m_ovf    = real_insn && ovf;
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("m_valid",    W'(Valid_Mem),    W'(m_valid));
      chk("m_regwr",    W'(RegWr_Mem),    W'(m_regwr));
      chk("m_memwr",    W'(MemWr_Mem),    W'(m_memwr));
      chk("m_wrbyte",   W'(WrByte_Mem),   W'(m_wrbyte));
      chk("m_memtoreg", W'(MemToReg_Mem), W'(m_m2r));
      chk("m_redirect", W'(Redirect_Mem), W'(m_redir));
      chk("m_ovfexc",   W'(OvfExc_Mem),   W'(m_ovf));
      if (m_valid) begin
        chk("m_alu",      ALU_ans_Mem,       m_alu);
        chk("m_busb",     busB_Mem,          m_busb);
        chk("m_wrdata",   WrData_Mem,        m_wrdata);
        chk("m_bypass",   Ex_Mem_ByPassing,  m_wrdata);
        chk("m_target",   W'(Reg_Target_Mem), W'(m_tgt));
        chk("m_loadbyte", W'(LoadByte_Mem),  W'(m_lb));
        chk("m_raddr",    Redirect_Addr_Mem, m_raddr);
      end
    end
  end

  task automatic nop();
    Stall = 0; Flush = 0;
    ALU_ans_Ex = '0; busB_out_Ex = '0; B_Addr_Ex = '0; J_Addr_out_Ex = '0; PC_Addr_Ex = '0;
    Reg_Target_Ex = '0; ZF_Ex = 0; OF_Ex = 0; Sign_Ex = 0; Branch_Ex = 0; Jump_Ex = 0;
    Jal_Ex = 0; MemToReg_Ex = 0; RegWr_Ex = 0; MemWr_Ex = 0; WrByte_Ex = 0; LoadByte_Ex = '0;
  endtask

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  W'(Valid_Mem), '0);
    chk({tag, "_regwr"},  W'(RegWr_Mem), '0);
    chk({tag, "_memwr"},  W'(MemWr_Mem), '0);
    chk({tag, "_redir"},  W'(Redirect_Mem), '0);
    chk({tag, "_wrdata"}, WrData_Mem, '0);
    chk({tag, "_raddr"},  Redirect_Addr_Mem, '0);
  endtask

  initial begin
    rst = 1'b1;
    nop();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Plain ALU write
    nop(); ALU_ans_Ex = 32'h0000_1234; RegWr_Ex = 1; Reg_Target_Ex = 5'd8;
    go();
    chk("alu_wrdata", WrData_Mem, 32'h1234);
    chk("alu_bypass", Ex_Mem_ByPassing, 32'h1234);
    chk("alu_target", W'(Reg_Target_Mem), 32'd8);
    chk("alu_regwr",  W'(RegWr_Mem), 32'd1);
    chk("alu_redir",  W'(Redirect_Mem), 32'd0);

    // Taken branch: one-cycle pulse
    nop(); Branch_Ex = 1; ZF_Ex = 1; B_Addr_Ex = 32'h40;
    go();
    chk("br_redir", W'(Redirect_Mem), 32'd1);
    chk("br_addr",  Redirect_Addr_Mem, 32'h40);
    nop();
    go();
    chk("br_pulse_end", W'(Redirect_Mem), 32'd0);
    nop(); Branch_Ex = 1; ZF_Ex = 0; B_Addr_Ex = 32'h40;
    go();
    chk("br_not_taken", W'(Redirect_Mem), 32'd0);

    // Branch and jump together: jump target wins
    nop(); Branch_Ex = 1; ZF_Ex = 1; Jump_Ex = 1; B_Addr_Ex = 32'h40; J_Addr_out_Ex = 32'h300;
    go();
    chk("brj_addr", Redirect_Addr_Mem, 32'h300);
    // Back-to-back taken instructions
    nop(); Jump_Ex = 1; J_Addr_out_Ex = 32'h380;
    go();
    chk("b2b_redir", W'(Redirect_Mem), 32'd1);
    chk("b2b_addr",  Redirect_Addr_Mem, 32'h380);

    // Jal
    nop(); Jal_Ex = 1; PC_Addr_Ex = 32'h104; J_Addr_out_Ex = 32'h200; ALU_ans_Ex = 32'hDEAD; Reg_Target_Ex = 5'd3;
    go();
    chk("jal_wrdata", WrData_Mem, 32'h104);
    chk("jal_bypass", Ex_Mem_ByPassing, 32'h104);
    chk("jal_target", W'(Reg_Target_Mem), 32'd31);
    chk("jal_regwr",  W'(RegWr_Mem), 32'd1);
    chk("jal_raddr",  Redirect_Addr_Mem, 32'h200);

    // Stall holds a store (and its redirect) for 3 cycles, then flush-with-stall bubbles it
    nop(); MemWr_Ex = 1; Jump_Ex = 1; J_Addr_out_Ex = 32'h80; busB_out_Ex = 32'hCAFE;
    go();
    nop(); Stall = 1; ALU_ans_Ex = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      go();
      chk("stall_memwr", W'(MemWr_Mem), 32'd1);
      chk("stall_redir", W'(Redirect_Mem), 32'd1);
      chk("stall_busb",  busB_Mem, 32'hCAFE);
    end
    Flush = 1;
    go();
    chk("flush_valid", W'(Valid_Mem), 32'd0);
    chk("flush_memwr", W'(MemWr_Mem), 32'd0);
    chk("flush_redir", W'(Redirect_Mem), 32'd0);

    // Overflow handling
    nop(); OF_Ex = 1; RegWr_Ex = 1; ALU_ans_Ex = 32'h8000_0000;
    go();
    chk("ovf_regwr",  W'(RegWr_Mem),  OVF_EN ? 32'd0 : 32'd1);
    chk("ovf_exc",    W'(OvfExc_Mem), OVF_EN ? 32'd1 : 32'd0);

    // Asynchronous reset mid-stall
    nop(); RegWr_Ex = 1; ALU_ans_Ex = 32'h77; Reg_Target_Ex = 5'd9; Jump_Ex = 1; J_Addr_out_Ex = 32'h90;
    go();
    Stall = 1;
    go();
    #1 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    #4 rst = 1'b0;
    nop();

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 1500; n++) begin
      ALU_ans_Ex    = $urandom; busB_out_Ex = $urandom; B_Addr_Ex = $urandom;
      J_Addr_out_Ex = $urandom; PC_Addr_Ex  = $urandom;
      Reg_Target_Ex = 5'($urandom); LoadByte_Ex = 2'($urandom);
      ZF_Ex = 1'($urandom); OF_Ex = ($urandom_range(0, 3) == 0); Sign_Ex = 1'($urandom);
      Branch_Ex = ($urandom_range(0, 2) == 0); Jump_Ex = ($urandom_range(0, 7) == 0);
      Jal_Ex = ($urandom_range(0, 7) == 0);
      MemToReg_Ex = 1'($urandom); RegWr_Ex = 1'($urandom);
      MemWr_Ex = 1'($urandom); WrByte_Ex = 1'($urandom);
      Stall = ($urandom_range(0, 4) == 0); Flush = ($urandom_range(0, 6) == 0);
      go();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage_reg.md
# ex_mem_stage_reg

Pipeline register and control-resolution block between the Exec stage and the Mem stage of the 5-stage MIPS pipeline. It captures the Exec results (ALU result, store data, branch/jump targets, destination register, control bits) on each clock. It resolves branch/jump redirection, forms the Ex/Mem forwarding value, and inserts bubbles on flush while holding on stall. All outputs are registered.

## Interface
Parameters:
- WIDTH, 32, datapath width
- LINK_REG, 5'd31, destination register forced for Jal

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Stall  in  1  hold all state (hazard unit)
- Flush  in  1  load a bubble (hazard unit / redirect)
- ALU_ans_Ex, busB_out_Ex, B_Addr_Ex, J_Addr_out_Ex, PC_Addr_Ex  in  WIDTH each  Exec results; PC_Addr_Ex is PC+4 of the instruction
- Reg_Target_Ex  in  5  destination register
- ZF_Ex, OF_Ex, Sign_Ex  in  1 each  ALU flags
- Branch_Ex, Jump_Ex, Jal_Ex, MemToReg_Ex, RegWr_Ex, MemWr_Ex, WrByte_Ex  in  1 each  control
- LoadByte_Ex  in  2  load width/sign select
- ALU_ans_Mem, busB_Mem  out  WIDTH  address / store data
- WrData_Mem  out  WIDTH  ALU result, or link address when Jal
- Reg_Target_Mem  out  5
- MemToReg_Mem, RegWr_Mem, MemWr_Mem, WrByte_Mem  out  1 each
- LoadByte_Mem  out  2
- Redirect_Mem  out  1  taken branch or jump
- Redirect_Addr_Mem  out  WIDTH  new PC
- Ex_Mem_ByPassing  out  WIDTH  forwarding value (= WrData_Mem)
- Valid_Mem  out  1  slot holds a real instruction
- OvfExc_Mem  out  1  overflow exception (macro only)

## Operation
- Each unstalled edge loads: Valid_Mem <= ~Flush. Data fields load every unstalled edge regardless of Flush.
- Taken = (Branch_Ex & ZF_Ex) | Jump_Ex | Jal_Ex.
  - Redirect_Addr_Mem <= Jump_Ex|Jal_Ex ? J_Addr_out_Ex : B_Addr_Ex.
  - When both Branch_Ex and Jump_Ex are set, the jump target wins.
- Jal: WrData_Mem <= PC_Addr_Ex; Reg_Target_Mem <= LINK_REG; RegWr_Mem <= 1. Otherwise WrData_Mem <= ALU_ans_Ex.
- Gating by Valid_Mem, applied at the registered outputs: when Valid_Mem=0, RegWr_Mem, MemWr_Mem, WrByte_Mem, MemToReg_Mem and Redirect_Mem read 0. Data outputs are don't-care.
- Ex_Mem_ByPassing equals WrData_Mem, so forwarding of a Jal link value is correct.

## Timing
- Latency 1 cycle, Ex to Mem.
- Reset, asynchronous: all outputs 0, Valid_Mem=0, Redirect_Addr_Mem=0. The first edge after deassertion loads normally.
- Priority is rst > Flush > Stall > load.
  - Flush with Stall: a bubble is loaded, not held.
  - Stall alone: every register holds, and Redirect_Mem stays asserted if it was asserted.
- Redirect_Mem is high for exactly one cycle per taken instruction when unstalled. The hazard unit is responsible for flushing younger stages.
- Back-to-back taken instructions each produce their own one-cycle Redirect_Mem pulse.
- rst asserted mid-stall clears state immediately; the held instruction is lost.

## Configuration
- OVERFLOW_TRAP_EN defined:
  - OF_Ex=1 with RegWr_Ex=1 (non-Jal) loads RegWr_Mem=0 and OvfExc_Mem=1 for that slot.
  - OvfExc_Mem is gated by Valid_Mem.
  - Redirect is unaffected.
- OVERFLOW_TRAP_EN undefined:
  - OF_Ex is ignored and the overflowed result is written back.
  - OvfExc_Mem is tied 0.

## Test plan
- Reset asserted asynchronously mid-cycle -> all outputs 0 before the next edge; Valid_Mem=0.
- ALU_ans_Ex=0x0000_1234, RegWr_Ex=1, Reg_Target_Ex=8 -> next cycle WrData_Mem=Ex_Mem_ByPassing=0x1234, Reg_Target_Mem=8, RegWr_Mem=1, Redirect_Mem=0.
- Branch_Ex=1, ZF_Ex=1, B_Addr_Ex=0x40 -> Redirect_Mem=1 for exactly one cycle, Redirect_Addr_Mem=0x40. With ZF_Ex=0 -> Redirect_Mem=0.
- Jal_Ex=1, PC_Addr_Ex=0x104, J_Addr_out_Ex=0x200 -> WrData_Mem=0x104, Reg_Target_Mem=31, RegWr_Mem=1, Redirect_Addr_Mem=0x200.
- MemWr_Ex=1 with Stall=1 for 3 cycles, then Flush=1 with Stall=1:
  - Outputs hold for 3 cycles.
  - Then Valid_Mem=0 and MemWr_Mem=0.
- OF_Ex=1, RegWr_Ex=1:
  - With OVERFLOW_TRAP_EN -> RegWr_Mem=0, OvfExc_Mem=1.
  - Without it -> RegWr_Mem=1, OvfExc_Mem=0.
